// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the streaming expression checker.
package expr_pkg;

  typedef enum logic [1:0] {
    EXPECT = 2'd0,
    NUM    = 2'd1,
    CLOSE  = 2'd2,
    ERR    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CC_DIGIT  = 3'd0,
    CC_OP     = 3'd1,
    CC_LPAREN = 3'd2,
    CC_RPAREN = 3'd3,
    CC_OTHER  = 3'd4
  } char_class_t;

  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;

endpackage

// File: rtl/expr_char_class.sv
// Combinational classifier of one ASCII character into grammar token classes.
// SUB_DIV_EN=0 demotes '-' and '/' to illegal characters.
module expr_char_class
  import expr_pkg::*;
#(
  parameter int SUB_DIV_EN = 1
) (
  input  logic [7:0]  ch_i,
  output char_class_t cls_o
);

  logic is_sub_div;

  assign is_sub_div = (ch_i == CH_MINUS) || (ch_i == CH_SLASH);

  // NOTE: cls_o gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    cls_o = CC_OTHER;
    if (ch_i >= CH_ZERO && ch_i <= CH_NINE) begin
      cls_o = CC_DIGIT;
    end else if (ch_i == CH_PLUS || ch_i == CH_STAR) begin
      cls_o = CC_OP;
    end else if (is_sub_div && SUB_DIV_EN != 0) begin
      cls_o = CC_OP;
    end else if (ch_i == CH_LPAREN) begin
      cls_o = CC_LPAREN;
    end else if (ch_i == CH_RPAREN) begin
      cls_o = CC_RPAREN;
    end
  end

endmodule

// File: rtl/expr_nest.sv
// Streaming validator for digit/operator/parenthesis expressions, one char per valid cycle.
// Define EXPR_ERRPOS_EN to add a character counter and the err_pos port.
module expr_nest
  import expr_pkg::*;
#(
  parameter int MAX_DEPTH  = 7,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1),
  parameter int SUB_DIV_EN = 1,
  parameter int POS_W      = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
`ifdef EXPR_ERRPOS_EN
  ,
  output logic [POS_W-1:0]   err_pos
`endif
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

  char_class_t          cls;
  state_t               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 out_q, out_d;
  logic                 err_q;

  expr_char_class #(.SUB_DIV_EN(SUB_DIV_EN)) u_class (
    .ch_i  (in),
    .cls_o (cls)
  );

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    case (state_q)
      EXPECT: begin
        if (cls == CC_DIGIT) begin
          state_d = NUM;
        end else if (cls == CC_LPAREN && depth_q < DEPTH_MAX) begin
          depth_d = depth_q + DEPTH_W'(1);
        end else begin
          state_d = ERR;
        end
      end
      NUM, CLOSE: begin
        // A digit may only extend a number; after ')' it is illegal.
        if (cls == CC_DIGIT && state_q == NUM) begin
          state_d = NUM;
        end else if (cls == CC_OP) begin
          state_d = EXPECT;
        end else if (cls == CC_RPAREN && depth_q != '0) begin
          state_d = CLOSE;
          depth_d = depth_q - DEPTH_W'(1);
        end else begin
          state_d = ERR;
        end
      end
      default: state_d = ERR;
    endcase
  end

  assign out_d = (state_d == NUM || state_d == CLOSE) && (depth_d == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= EXPECT;
      depth_q <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (in_valid) begin
      state_q <= state_d;
      depth_q <= depth_d;
      out_q   <= out_d;
      err_q   <= (state_d == ERR);
    end
  end

`ifdef EXPR_ERRPOS_EN
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] err_pos_q;

  // The counter value before increment is the 0-based index of the char being consumed.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pos_q     <= '0;
      err_pos_q <= '0;
    end else if (in_valid) begin
      if (pos_q != '1) begin
        pos_q <= pos_q + POS_W'(1);
      end
      if (state_q != ERR && state_d == ERR) begin
        err_pos_q <= pos_q;
      end
    end
  end

  assign err_pos = err_pos_q;
`endif

  assign out   = out_q;
  assign err   = err_q;
  assign depth = depth_q;

endmodule

// File: tb/tb_expr_nest.sv
// Directed bench for expr_nest: default, MAX_DEPTH=2 and SUB_DIV_EN=0 instances share stimulus.
// Define EXPR_ERRPOS_EN to also check err_pos.
module tb_expr_nest;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch = 8'h00;

  logic       out_a, err_a;
  logic [2:0] depth_a;
  logic       out_b, err_b;
  logic [1:0] depth_b;
  logic       out_c, err_c;
  logic [2:0] depth_c;
`ifdef EXPR_ERRPOS_EN
  logic [15:0] err_pos_a, err_pos_b, err_pos_c;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  expr_nest dut_a (
    .clk(clk), .clr(clr), .in(in_ch), .in_valid(in_valid),
    .out(out_a), .err(err_a), .depth(depth_a)
`ifdef EXPR_ERRPOS_EN
    , .err_pos(err_pos_a)
`endif
  );

  expr_nest #(.MAX_DEPTH(2)) dut_b (
    .clk(clk), .clr(clr), .in(in_ch), .in_valid(in_valid),
    .out(out_b), .err(err_b), .depth(depth_b)
`ifdef EXPR_ERRPOS_EN
    , .err_pos(err_pos_b)
`endif
  );

  expr_nest #(.SUB_DIV_EN(0)) dut_c (
    .clk(clk), .clr(clr), .in(in_ch), .in_valid(in_valid),
    .out(out_c), .err(err_c), .depth(depth_c)
`ifdef EXPR_ERRPOS_EN
    , .err_pos(err_pos_c)
`endif
  );

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    in_ch    = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    in_valid = 1'b0;
    clr = 1'b1;
    #1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if ({out_a, err_a, depth_a, out_b, err_b, depth_b, out_c, err_c, depth_c} !== 13'b0) begin
      failures++;
      $display("FAIL reset_outputs got a=%b%b%b b=%b%b%b c=%b%b%b want all zero",
               out_a, err_a, depth_a, out_b, err_b, depth_b, out_c, err_c, depth_c);
    end
`ifdef EXPR_ERRPOS_EN
    checks++;
    if (err_pos_a !== 16'd0) begin
      failures++;
      $display("FAIL reset_err_pos got=%0d want=0", err_pos_a);
    end
`endif
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_simple();
    string s = "12+3";
    logic exp_out [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      send(s[i]);
      checks++;
      if (out_a !== exp_out[i] || err_a !== 1'b0 || depth_a !== 3'd0) begin
        failures++;
        $display("FAIL simple[%0d] got out=%b err=%b depth=%0d want out=%b err=0 depth=0",
                 i, out_a, err_a, depth_a, exp_out[i]);
      end
    end
  endtask

  task automatic test_nested();
    string s = "(4*(5+6))";
    int exp_depth [9] = '{1, 1, 1, 2, 2, 2, 2, 1, 0};
    pulse_clr();
    for (int i = 0; i < 9; i++) begin
      send(s[i]);
      checks++;
      if (depth_a !== 3'(exp_depth[i]) || out_a !== (i == 8) || err_a !== 1'b0) begin
        failures++;
        $display("FAIL nested[%0d] got depth=%0d out=%b err=%b want depth=%0d out=%b err=0",
                 i, depth_a, out_a, err_a, exp_depth[i], (i == 8));
      end
    end
  endtask

  task automatic test_max_depth();
    int exp_depth [3] = '{1, 2, 2};
    logic exp_err [3] = '{1'b0, 1'b0, 1'b1};
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      send("(");
      checks++;
      if (depth_b !== 2'(exp_depth[i]) || err_b !== exp_err[i] || out_b !== 1'b0) begin
        failures++;
        $display("FAIL max_depth[%0d] got depth=%0d err=%b out=%b want depth=%0d err=%b out=0",
                 i, depth_b, err_b, out_b, exp_depth[i], exp_err[i]);
      end
    end
    checks++;
    if (depth_a !== 3'd3 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL max_depth_default got depth=%0d err=%b want depth=3 err=0", depth_a, err_a);
    end
`ifdef EXPR_ERRPOS_EN
    checks++;
    if (err_pos_b !== 16'd2) begin
      failures++;
      $display("FAIL max_depth_err_pos got=%0d want=2", err_pos_b);
    end
`endif
  endtask

  task automatic test_sub_div();
    string s = "7-1";
    logic exp_err_c [3] = '{1'b0, 1'b1, 1'b1};
    logic exp_out_a [3] = '{1'b1, 1'b0, 1'b1};
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      send(s[i]);
      checks++;
      if (err_c !== exp_err_c[i] || out_c !== (i == 0)) begin
        failures++;
        $display("FAIL no_sub_div[%0d] got err=%b out=%b want err=%b out=%b",
                 i, err_c, out_c, exp_err_c[i], (i == 0));
      end
      checks++;
      if (out_a !== exp_out_a[i] || err_a !== 1'b0) begin
        failures++;
        $display("FAIL sub_div[%0d] got out=%b err=%b want out=%b err=0",
                 i, out_a, err_a, exp_out_a[i]);
      end
    end
    send("/");
    send("0");
    checks++;
    if (out_a !== 1'b1 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL div_op got out=%b err=%b want out=1 err=0", out_a, err_a);
    end
  endtask

  task automatic test_err_sticky();
    string s = "3)+4";
    logic exp_out [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_err [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      send(s[i]);
      checks++;
      if (out_a !== exp_out[i] || err_a !== exp_err[i] || depth_a !== 3'd0) begin
        failures++;
        $display("FAIL sticky[%0d] got out=%b err=%b depth=%0d want out=%b err=%b depth=0",
                 i, out_a, err_a, depth_a, exp_out[i], exp_err[i]);
      end
    end
`ifdef EXPR_ERRPOS_EN
    checks++;
    if (err_pos_a !== 16'd1) begin
      failures++;
      $display("FAIL sticky_err_pos got=%0d want=1", err_pos_a);
    end
`endif
    @(negedge clk);
    clr = 1'b1;
    #1;
    checks++;
    if (out_a !== 1'b0 || err_a !== 1'b0 || depth_a !== 3'd0) begin
      failures++;
      $display("FAIL sticky_clr got out=%b err=%b depth=%0d want all 0", out_a, err_a, depth_a);
    end
    @(negedge clk);
    clr = 1'b0;
    send("9");
    checks++;
    if (out_a !== 1'b1 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL sticky_recover got out=%b err=%b want out=1 err=0", out_a, err_a);
    end
  endtask

  task automatic test_stall();
    pulse_clr();
    send("5");
    @(negedge clk);
    in_ch    = "+";
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_a !== 1'b1 || err_a !== 1'b0 || depth_a !== 3'd0) begin
        failures++;
        $display("FAIL stall[%0d] got out=%b err=%b depth=%0d want out=1 err=0 depth=0",
                 i, out_a, err_a, depth_a);
      end
    end
    send("+");
    checks++;
    if (out_a !== 1'b0 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL stall_resume got out=%b err=%b want out=0 err=0", out_a, err_a);
    end
  endtask

  task automatic test_illegal_sequences();
    // Each pair: prefix that is legal, then the offending char.
    string s [4] = '{"()", "(1)(", "(1)2", "00a"};
    int    bad_idx [4] = '{1, 3, 3, 2};
    for (int t = 0; t < 4; t++) begin
      pulse_clr();
      for (int i = 0; i < s[t].len(); i++) begin
        send(s[t][i]);
        checks++;
        if (err_a !== (i >= bad_idx[t]) || (err_a === 1'b1 && out_a !== 1'b0)) begin
          failures++;
          $display("FAIL illegal[%0d][%0d] got err=%b out=%b want err=%b",
                   t, i, err_a, out_a, (i >= bad_idx[t]));
        end
      end
`ifdef EXPR_ERRPOS_EN
      checks++;
      if (err_pos_a !== 16'(bad_idx[t])) begin
        failures++;
        $display("FAIL illegal_err_pos[%0d] got=%0d want=%0d", t, err_pos_a, bad_idx[t]);
      end
`endif
    end
  endtask

  task automatic test_clr_mid_expr();
    pulse_clr();
    send("(");
    send("(");
    checks++;
    if (depth_a !== 3'd2) begin
      failures++;
      $display("FAIL clr_mid_pre got depth=%0d want=2", depth_a);
    end
    pulse_clr();
    send("8");
    checks++;
    if (out_a !== 1'b1 || depth_a !== 3'd0 || err_a !== 1'b0) begin
      failures++;
      $display("FAIL clr_mid_post got out=%b depth=%0d err=%b want out=1 depth=0 err=0",
               out_a, depth_a, err_a);
    end
    send("x");
`ifdef EXPR_ERRPOS_EN
    checks++;
    if (err_pos_a !== 16'd1) begin
      failures++;
      $display("FAIL clr_mid_err_pos got=%0d want=1", err_pos_a);
    end
`endif
    checks++;
    if (err_a !== 1'b1 || out_a !== 1'b0) begin
      failures++;
      $display("FAIL clr_mid_err got err=%b out=%b want err=1 out=0", err_a, out_a);
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_nested();
    test_max_depth();
    test_sub_div();
    test_err_sticky();
    test_stall();
    test_illegal_sequences();
    test_clr_mid_expr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/expr_nest.md
EXPR_NEST -- requirements
Module: expr_nest

Interface
REQ-001 Parameter MAX_DEPTH, default 7: maximum parenthesis nesting depth accepted, range 1..255.
REQ-002 Parameter DEPTH_W, default $clog2(MAX_DEPTH+1): width of depth counter and depth output.
REQ-003 Parameter SUB_DIV_EN, default 1: 1 = '-' and '/' are operators in addition to '+' and '*'; 0 = '+' and '*' only.
REQ-004 Parameter POS_W, default 16: width of character-position counter (used only with EXPR_ERRPOS_EN).
REQ-005 One clock; reset is asynchronous and active-high; ports named clk and clr.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 clr  input  1  asynchronous active-high reset.
REQ-008 in  input  8  ASCII character.
REQ-009 in_valid  input  1  in is consumed on a rising clk edge only when high.
REQ-010 out  output  1  registered; high when the characters consumed so far form a complete valid expression.
REQ-011 err  output  1  registered, sticky; high once any illegal character has been consumed.
REQ-012 depth  output  DEPTH_W  current open-parenthesis count.
REQ-013 err_pos  output  POS_W  0-based index of first illegal character (present only with EXPR_ERRPOS_EN).

Function
REQ-014 Grammar: expr := operand (op operand)*; operand := digit+ | '(' expr ')'; digit = "0".."9"; no whitespace is legal.
REQ-015 State machine with four states: EXPECT (operand needed), NUM (inside number), CLOSE (after ')'), ERR.
REQ-016 EXPECT: digit -> NUM; '(' with depth<MAX_DEPTH -> EXPECT, depth+1; '(' with depth==MAX_DEPTH -> ERR; any other character -> ERR.
REQ-017 NUM: digit -> NUM (multi-digit, leading zeros legal); op -> EXPECT; ')' with depth>0 -> CLOSE, depth-1; ')' with depth==0 -> ERR; other -> ERR.
REQ-018 CLOSE: op -> EXPECT; ')' handled as in NUM; digit, '(' or other -> ERR.
REQ-019 ERR is absorbing until clr; depth freezes at its value when ERR is entered.
REQ-020 All state, depth, out, err updates occur only on edges with in_valid=1; with in_valid=0 every register holds.
REQ-021 out on the edge consuming a character = 1 iff next state is NUM or CLOSE and next depth==0; otherwise 0; latency one cycle.
REQ-022 err = 1 iff state is ERR; asserted on the same edge the illegal character is consumed; out is 0 whenever err is 1.

Reset
REQ-023 clr asserted: state EXPECT, depth 0, out 0, err 0, position counter 0, err_pos 0, immediately and independent of clk.
REQ-024 clr mid-expression discards all partial state; the first valid character after clr release is index 0 of a new expression.

Configuration
REQ-025 Macro EXPR_ERRPOS_EN defined: position counter counts consumed characters (saturating at 2^POS_W-1); err_pos latches the counter value on the edge entering ERR and holds until clr.
REQ-026 Macro EXPR_ERRPOS_EN undefined: no position counter, no err_pos port; all other behaviour identical.

Structure
REQ-027 Shared package expr_pkg holds the state enum (EXPECT, NUM, CLOSE, ERR) and ASCII constants for digits, operators and parentheses.
REQ-028 One sub-module expr_char_class: combinational classifier of in into {digit, op, lparen, rparen, other}, taking SUB_DIV_EN.

Verification
REQ-029 "12+3" -> out 1,1,0,1 after each char; err 0; depth 0.
REQ-030 "(4*(5+6))" -> depth 1,1,1,2,2,2,2,1,0; out high only after final ')'.
REQ-031 MAX_DEPTH=2, "(((" -> err rises on third '('; depth stays 2; err_pos=2 with EXPR_ERRPOS_EN.
REQ-032 SUB_DIV_EN=0, "7-1" -> err on '-'; SUB_DIV_EN=1 same input -> out 1 after '1'.
REQ-033 "3)" -> err on ')'; then "+4" -> err stays 1, out stays 0; clr -> all outputs 0; "9" -> out 1.
REQ-034 "5", in_valid low 3 cycles with in="+", then "+" valid -> out held 1 during stall, 0 after '+'.
